// File: rtl/cordic_rom_ctrl_pkg.sv
// Shared types and constants for the CORDIC coefficient ROM controller.
package cordic_rom_ctrl_pkg;

  localparam int unsigned AW_DEF    = 6;
  localparam int unsigned DW_DEF    = 48;
  localparam int unsigned DEPTH_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  // Polarity of the ROM wen pin, which also steers the MUX_2_6 address select.
  localparam logic ROM_WRITE = 1'b0;
  localparam logic ROM_READ  = 1'b1;

endpackage

// File: rtl/cordic_rom_ctrl_if.sv
// Bundle of loader stream, two channel requests, response and ROM pins.
interface cordic_rom_ctrl_if
  import cordic_rom_ctrl_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
);

  logic          load_start;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_ready;
  logic          loaded;

  logic          req0_valid;
  logic [AW-1:0] req0_addr;
  logic          req0_gnt;
  logic          req1_valid;
  logic [AW-1:0] req1_addr;
  logic          req1_gnt;

  logic          rom_cen;
  logic          rom_wen;
  logic [AW-1:0] rom_index_rea;
  logic [AW-1:0] rom_index_wri;
  logic [DW-1:0] rom_d;
  logic [DW-1:0] rom_q;

  logic          rsp_valid;
  logic          rsp_id;
  logic [DW-1:0] rsp_data;

  // Controller side.
  modport slave (
    input  load_start, load_valid, load_data,
    output load_ready, loaded,
    input  req0_valid, req0_addr, req1_valid, req1_addr,
    output req0_gnt, req1_gnt,
    output rom_cen, rom_wen, rom_index_rea, rom_index_wri, rom_d,
    input  rom_q,
    output rsp_valid, rsp_id, rsp_data
  );

  // Loader, channels and ROM side.
  modport master (
    output load_start, load_valid, load_data,
    input  load_ready, loaded,
    output req0_valid, req0_addr, req1_valid, req1_addr,
    input  req0_gnt, req1_gnt,
    input  rom_cen, rom_wen, rom_index_rea, rom_index_wri, rom_d,
    output rom_q,
    input  rsp_valid, rsp_id, rsp_data
  );

endinterface

// File: rtl/cordic_rom_rr_arb.sv
// Two-requester round-robin arbiter; on a tie the channel not granted last wins.
module cordic_rom_rr_arb (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic last_gnt;

  assign gnt0 = enable & req0 & (~req1 | last_gnt);
  assign gnt1 = enable & req1 & (~req0 | ~last_gnt);

  // Starts at 1 so channel 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt <= 1'b1;
    end else if (gnt0 | gnt1) begin
      last_gnt <= gnt1;
    end
  end

endmodule

// File: rtl/cordic_rom_ctrl.sv
// Loads the 64x48 CORDIC coefficient ROM from a stream, then arbitrates
// read access between two channels with a one-cycle registered response.
module cordic_rom_ctrl
  import cordic_rom_ctrl_pkg::*;
#(
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  cordic_rom_ctrl_if.slave bus
);

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rea_q;
  logic          loaded_q;
  logic          rsp_valid_q;
  logic          rsp_id_q;
  logic [DW-1:0] rsp_data_q;

  logic          wr_en;
  logic          rd_en;
  logic          gnt0;
  logic          gnt1;

  // A load_start cycle never accepts a word or grants a read.
  assign wr_en = ~reset & (state == ST_LOAD) & ~bus.load_start & bus.load_valid;
  assign rd_en = ~reset & (state == ST_READY) & ~bus.load_start;

  cordic_rom_rr_arb u_arb (
    .clk    (clk),
    .reset  (reset),
    .enable (rd_en),
    .req0   (bus.req0_valid),
    .req1   (bus.req1_valid),
    .gnt0   (gnt0),
    .gnt1   (gnt1)
  );

  // Load sequencer: IDLE -> LOAD (DEPTH accepts) -> READY, reload on load_start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      wr_ptr   <= '0;
      loaded_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          loaded_q <= 1'b0;
          if (bus.load_start) begin
            state  <= ST_LOAD;
            wr_ptr <= '0;
          end
        end
        ST_LOAD: begin
          if (bus.load_start) begin
            wr_ptr <= '0;
          end else if (bus.load_valid) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (wr_ptr == AW'(DEPTH - 1)) begin
              state    <= ST_READY;
              loaded_q <= 1'b1;
            end
          end
        end
        ST_READY: begin
          if (bus.load_start) begin
            state    <= ST_LOAD;
            loaded_q <= 1'b0;
            wr_ptr   <= '0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          loaded_q <= 1'b0;
          wr_ptr   <= '0;
        end
      endcase
    end
  end

  // Read response path; rea_q keeps the last granted address on idle cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      rea_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= gnt0 | gnt1;
      if (gnt0 | gnt1) begin
        rea_q      <= bus.rom_index_rea;
        rsp_id_q   <= gnt1;
        rsp_data_q <= bus.rom_q;
      end
    end
  end

  assign bus.load_ready    = ~reset & (state == ST_LOAD) & ~bus.load_start;
  assign bus.loaded        = loaded_q;
  assign bus.req0_gnt      = gnt0;
  assign bus.req1_gnt      = gnt1;

  assign bus.rom_cen       = 1'b1;
  assign bus.rom_wen       = wr_en ? ROM_WRITE : ROM_READ;
  assign bus.rom_index_wri = wr_ptr;
  assign bus.rom_d         = wr_en ? bus.load_data : '0;
  assign bus.rom_index_rea = gnt1 ? bus.req1_addr : (gnt0 ? bus.req0_addr : rea_q);

  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_id        = rsp_id_q;
  assign bus.rsp_data      = rsp_data_q;

endmodule
